// File: rtl/multi_ch_pulse_delay_pkg.sv
// Shared types and helpers for the multi-channel trigger-to-pulse delay block.
package multi_ch_pulse_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RETRIG  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/pulse_delay_ch.sv
// One channel: config register, trigger edge detect, delay/pulse FSM and counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | armed, waiting for a rising edge on trig_in
// ST_WAIT  | counting the latched delay (us_cnt x REFCLK_F sub-cycles)
// ST_PULSE | driving pulse_out for the latched width (pw_cnt)
module pulse_delay_ch
    import multi_ch_pulse_delay_pkg::*;
#(
    parameter int REFCLK_F = 100,
    parameter int DLY_W    = 16,
    parameter int PW_W     = 8
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [DLY_W-1:0] cfg_dly,
    input  logic [PW_W-1:0]  cfg_pw,
    input  logic             cfg_mode,
    input  logic             trig_in,
    output logic             pulse_out,
    output logic             busy,
    output logic             trig_drop
);

    localparam int SUB_W = (clog2(REFCLK_F) < 1) ? 1 : clog2(REFCLK_F);
    localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(REFCLK_F - 1);

    state_t state, state_d;

    logic [DLY_W-1:0] cfg_dly_q;
    logic [PW_W-1:0]  cfg_pw_q;
    logic             cfg_mode_q;

    logic [PW_W-1:0]  pw_l, pw_l_d;
    logic             mode_l, mode_l_d;

    logic [DLY_W-1:0] us_cnt, us_cnt_d;
    logic [SUB_W-1:0] sub_cnt, sub_cnt_d;
    logic [PW_W-1:0]  pw_cnt, pw_cnt_d;

    logic trig_q;
    logic rise;
    logic accept;
    logic drop_set;
    logic pulse_q;
    logic busy_q;
    logic drop_q;

    logic [PW_W-1:0] pw_first_cfg;
    logic [PW_W-1:0] pw_first_l;

    // A programmed width of 0 behaves as 1, so the counter load saturates at 0.
    assign pw_first_cfg = (cfg_pw_q == '0) ? '0 : cfg_pw_q - 1'b1;
    assign pw_first_l   = (pw_l == '0) ? '0 : pw_l - 1'b1;

    assign rise   = trig_in & ~trig_q;
    assign accept = rise && ((state == ST_IDLE) || (mode_l == MODE_RETRIG));

    always_comb begin
        state_d   = state;
        us_cnt_d  = us_cnt;
        sub_cnt_d = sub_cnt;
        pw_cnt_d  = pw_cnt;
        pw_l_d    = pw_l;
        mode_l_d  = mode_l;
        drop_set  = 1'b0;

        case (state)
            ST_WAIT: begin
                if (sub_cnt == '0) begin
                    if (us_cnt == '0) begin
                        state_d  = ST_PULSE;
                        pw_cnt_d = pw_first_l;
                    end else begin
                        us_cnt_d  = us_cnt - 1'b1;
                        sub_cnt_d = SUB_RELOAD;
                    end
                end else begin
                    sub_cnt_d = sub_cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (pw_cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    pw_cnt_d = pw_cnt - 1'b1;
                end
            end
            default: ;
        endcase

        if (rise && (state != ST_IDLE) && (mode_l == MODE_ONESHOT)) begin
            drop_set = 1'b1;
        end

        // Acceptance overrides the counting above; config comes from the
        // register contents before any same-edge write.
        if (accept) begin
            pw_l_d   = cfg_pw_q;
            mode_l_d = cfg_mode_q;
            if (cfg_dly_q == '0) begin
                state_d  = ST_PULSE;
                pw_cnt_d = pw_first_cfg;
            end else begin
                state_d   = ST_WAIT;
                us_cnt_d  = cfg_dly_q - 1'b1;
                sub_cnt_d = SUB_RELOAD;
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cfg_dly_q  <= '0;
            cfg_pw_q   <= PW_W'(1);
            cfg_mode_q <= MODE_ONESHOT;
            pw_l       <= PW_W'(1);
            mode_l     <= MODE_ONESHOT;
            us_cnt     <= '0;
            sub_cnt    <= '0;
            pw_cnt     <= '0;
            // Tracking the input during reset keeps a level held across release from looking like an edge.
            trig_q     <= trig_in;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state   <= state_d;
            pw_l    <= pw_l_d;
            mode_l  <= mode_l_d;
            us_cnt  <= us_cnt_d;
            sub_cnt <= sub_cnt_d;
            pw_cnt  <= pw_cnt_d;
            trig_q  <= trig_in;
            pulse_q <= (state_d == ST_PULSE);
            busy_q  <= (state_d != ST_IDLE);
            drop_q  <= drop_set | (drop_q & ~cfg_wr);
            if (cfg_wr) begin
                cfg_dly_q  <= cfg_dly;
                cfg_pw_q   <= cfg_pw;
                cfg_mode_q <= cfg_mode;
            end
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign trig_drop = drop_q;

endmodule

// File: rtl/multi_ch_pulse_delay.sv
// Multi-channel trigger-to-pulse delay: config address decode plus CH_NUM channels.
module multi_ch_pulse_delay
    import multi_ch_pulse_delay_pkg::*;
#(
    parameter int REFCLK_F = 100,
    parameter int CH_NUM   = 4,
    parameter int DLY_W    = 16,
    parameter int PW_W     = 8,
    localparam int CH_W    = (clog2(CH_NUM) < 1) ? 1 : clog2(CH_NUM)
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DLY_W-1:0]  cfg_dly,
    input  logic [PW_W-1:0]   cfg_pw,
    input  logic              cfg_mode,
    input  logic [CH_NUM-1:0] trig_in,
    output logic [CH_NUM-1:0] pulse_out,
    output logic [CH_NUM-1:0] busy,
    output logic [CH_NUM-1:0] trig_drop
);

    // Addresses at or above CH_NUM match no channel and are dropped.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

        pulse_delay_ch #(
            .REFCLK_F (REFCLK_F),
            .DLY_W    (DLY_W),
            .PW_W     (PW_W)
        ) u_ch (
            .ref_clk   (ref_clk),
            .reset     (reset),
            .cfg_wr    (wr_sel),
            .cfg_dly   (cfg_dly),
            .cfg_pw    (cfg_pw),
            .cfg_mode  (cfg_mode),
            .trig_in   (trig_in[i]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .trig_drop (trig_drop[i])
        );
    end

endmodule
